// File: rtl/vedic_pkg.sv
// Shared types and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned META_TAG_W = 4;
  localparam int unsigned MAX_W      = 64;

  // Sideband that travels alongside the arithmetic through every stage.
  typedef struct packed {
    logic                  neg;
    logic [META_TAG_W-1:0] tag;
  } stage_meta_t;

  // Places a quarter product at its weight within a double-width sum.
  function automatic logic [2*MAX_W-1:0] qp_align(input logic [MAX_W-1:0] q,
                                                  input int unsigned      sh);
    qp_align = (2*MAX_W)'(q) << sh;
  endfunction

endpackage

// File: rtl/vedic_mult_pipe_if.sv
// Operand and result valid/ready channels of the pipelined multiplier.
interface vedic_mult_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag, busy
  );

endinterface

// File: rtl/vedic_mult.sv
// Combinational unsigned Vedic multiplier; splits into four half-width
// products recursively down to 2-bit leaves.
module vedic_mult
  import vedic_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (W <= 2) begin : g_leaf
    assign p_o = (2*W)'(a_i) * (2*W)'(b_i);
  end else begin : g_split
    localparam int unsigned HW = W / 2;

    logic [W-1:0] q0;
    logic [W-1:0] q1;
    logic [W-1:0] q2;
    logic [W-1:0] q3;

    vedic_mult #(.W(HW)) u_q0 (.a_i(a_i[HW-1:0]), .b_i(b_i[HW-1:0]), .p_o(q0));
    vedic_mult #(.W(HW)) u_q1 (.a_i(a_i[W-1:HW]), .b_i(b_i[HW-1:0]), .p_o(q1));
    vedic_mult #(.W(HW)) u_q2 (.a_i(a_i[HW-1:0]), .b_i(b_i[W-1:HW]), .p_o(q2));
    vedic_mult #(.W(HW)) u_q3 (.a_i(a_i[W-1:HW]), .b_i(b_i[W-1:HW]), .p_o(q3));

    assign p_o = (2*W)'(qp_align(MAX_W'(q0), 32'd0))
               + (2*W)'(qp_align(MAX_W'(q1), HW))
               + (2*W)'(qp_align(MAX_W'(q2), HW))
               + (2*W)'(qp_align(MAX_W'(q3), W));
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage valid/ready signed/unsigned multiplier: operand magnitudes,
// Vedic quarter products, then sum and sign restore. Tag rides along.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = META_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mult_pipe_if.slave bus
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  // Stage valids: bit 0 = S1 (operands), bit 1 = S2 (quarters), bit 2 = S3 (result).
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;

  logic adv1_c;
  logic adv2_c;
  logic adv3_c;

  // S1 registers
  logic [WIDTH-1:0] a_mag_q;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] b_mag_d;
  stage_meta_t      meta1_q;
  stage_meta_t      meta1_d;

  // S2 registers
  logic [WIDTH-1:0] q0_q;
  logic [WIDTH-1:0] q0_d;
  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q1_d;
  logic [WIDTH-1:0] q2_q;
  logic [WIDTH-1:0] q2_d;
  logic [WIDTH-1:0] q3_q;
  logic [WIDTH-1:0] q3_d;
  stage_meta_t      meta2_q;
  stage_meta_t      meta2_d;

  // S3 registers
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    prod_d;
  logic [TAG_W-1:0] tag3_q;
  logic [TAG_W-1:0] tag3_d;

  // Combinational stage logic
  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic             neg_c;
  logic [WIDTH-1:0] q0_c;
  logic [WIDTH-1:0] q1_c;
  logic [WIDTH-1:0] q2_c;
  logic [WIDTH-1:0] q3_c;
  logic [PW-1:0]    mag_c;
  logic [PW-1:0]    signed_prod_c;

  // A stage moves when it is empty or its successor moves; bubbles collapse.
  assign adv3_c = !vld_q[2] || bus.out_ready;
  assign adv2_c = !vld_q[1] || adv3_c;
  assign adv1_c = !vld_q[0] || adv2_c;

  assign bus.in_ready    = adv1_c;
  assign bus.busy        = |vld_q;
  assign bus.out_valid   = vld_q[2];
  assign bus.out_product = prod_q;
  assign bus.out_tag     = tag3_q;

  // Most-negative input maps to 2^(WIDTH-1), which fits as unsigned.
  always_comb begin
    a_abs_c = bus.in_a;
    b_abs_c = bus.in_b;
    if (bus.in_signed && bus.in_a[WIDTH-1]) begin
      a_abs_c = (~bus.in_a) + WIDTH'(1);
    end
    if (bus.in_signed && bus.in_b[WIDTH-1]) begin
      b_abs_c = (~bus.in_b) + WIDTH'(1);
    end
    neg_c = bus.in_signed && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
  end

  vedic_mult #(.W(H)) u_q0 (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[H-1:0]),     .p_o(q0_c));
  vedic_mult #(.W(H)) u_q1 (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[H-1:0]),     .p_o(q1_c));
  vedic_mult #(.W(H)) u_q2 (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[WIDTH-1:H]), .p_o(q2_c));
  vedic_mult #(.W(H)) u_q3 (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[WIDTH-1:H]), .p_o(q3_c));

  // Quarter products recombined at 2*WIDTH bits; the sum cannot overflow.
  always_comb begin
    mag_c = PW'(qp_align(MAX_W'(q0_q), 32'd0))
          + PW'(qp_align(MAX_W'(q1_q), H))
          + PW'(qp_align(MAX_W'(q2_q), H))
          + PW'(qp_align(MAX_W'(q3_q), WIDTH));
    signed_prod_c = mag_c;
    if (meta2_q.neg) begin
      signed_prod_c = (~mag_c) + PW'(1);
    end
  end

  // Next-state: each stage loads only when it advances and its source holds a beat.
  always_comb begin
    vld_d   = vld_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    meta1_d = meta1_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    q3_d    = q3_q;
    meta2_d = meta2_q;
    prod_d  = prod_q;
    tag3_d  = tag3_q;

    if (adv1_c) begin
      vld_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        a_mag_d     = a_abs_c;
        b_mag_d     = b_abs_c;
        meta1_d.neg = neg_c;
        meta1_d.tag = META_TAG_W'(bus.in_tag);
      end
    end

    if (adv2_c) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        q0_d    = q0_c;
        q1_d    = q1_c;
        q2_d    = q2_c;
        q3_d    = q3_c;
        meta2_d = meta1_q;
      end
    end

    if (adv3_c) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) begin
        prod_d = signed_prod_c;
        tag3_d = TAG_W'(meta2_q.tag);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      meta1_q <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
      q3_q    <= '0;
      meta2_q <= '0;
      prod_q  <= '0;
      tag3_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      meta1_q <= meta1_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      meta2_q <= meta2_d;
      prod_q  <= prod_d;
      tag3_q  <= tag3_d;
    end
  end

endmodule
